core_lsu: RTL
=============

Name: core_lsu

Overview:
- Load/store execution stage directly downstream of the decoder cascade's preempt channel.
- Accepts one memory request when a decoder raises lsu_en (opcodes 8/9/A/B) and computes the TOY address: direct from instr[7:0], or indirect from R[t].
- Drives a single-outstanding memory bus handshake, writes R[d] back for loads, and pulses done so the sequencer releases the stall the decoder inserted.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 16, data word width.
- IO_ADDR, 8'hFF, address mapped to the stdio port when the optional feature is compiled in.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- lsu_en_i  in  1  request strobe from the preempt interface; sampled only in IDLE
- lsu_wen_i  in  1  1 = store, 0 = load
- lsu_kind_i  in  1  1 = direct address instr[7:0]; 0 = indirect, address R[t][ADDR_W-1:0]
- instr_i  in  16  instruction word of the requesting decoder
- rt_data_i  in  DATA_W  R[t] value, used as the indirect address
- rd_data_i  in  DATA_W  R[d] value, used as store data
- busy_o  out  1  request accepted and not yet completed
- done_o  out  1  one-cycle completion pulse
- arf_wen_o  out  1  register-file write enable, load write-back
- arf_waddr_o  out  4  write-back register index
- arf_wdata_o  out  DATA_W  write-back data
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory accept/complete, single cycle
- mem_rdata_i  in  DATA_W  read data, valid in the cycle mem_ack_i is high

Behaviour:
- Reset: state IDLE. busy_o, done_o, arf_wen_o, mem_req_o, mem_we_o = 0. mem_addr_o, mem_wdata_o, arf_waddr_o, arf_wdata_o = 0.
- State IDLE:
  - lsu_en_i=1 captures wen, rd = instr_i[11:8], address, and store data rd_data_i.
  - Moves to REQ. busy_o=1 from the next cycle.
- State REQ:
  - mem_req_o=1, mem_we_o=wen. Address and wdata are held stable until ack.
  - mem_ack_i=1 captures mem_rdata_i and moves to RESP.
  - mem_ack_i may arrive in the first REQ cycle; there is no cap on wait cycles.
- State RESP (one cycle):
  - mem_req_o=0, done_o=1, busy_o=0 in the following cycle.
  - For a load, arf_wen_o=1 in this same cycle, with arf_waddr_o=rd and arf_wdata_o=captured data.
  - A load with rd==0 suppresses arf_wen_o, but done_o still pulses.
  - Next state is IDLE.
- Minimum latency: accept at cycle N, mem_req at N+1, done at N+2 when ack comes at N+1.
- lsu_en_i while busy is ignored; the decoder's stall guarantees it does not occur, and the bench flags it as an assertion.
- lsu_en_i in the same cycle as done_o (RESP) is ignored. A new request is accepted only from IDLE.
- Indirect address is truncated to the low ADDR_W bits of R[t]. Upper bits are ignored with no fault.
- Reset mid-operation drops the pending access immediately: mem_req_o=0 in the cycle after rst_i, and no write-back or done.

Optional Feature:
- Macro: TOY_LSU_STDIO_EN.
- When defined, adds these ports:
  - stdin_valid_i, stdin_ready_o, stdin_data_i[DATA_W]
  - stdout_valid_o, stdout_ready_i, stdout_data_o[DATA_W]
- Any access to IO_ADDR bypasses the memory bus and mem_req_o stays 0.
  - Load from IO_ADDR: REQ asserts stdin_ready_o and waits for stdin_valid_i; that handshake cycle acts as the ack.
  - Store to IO_ADDR: REQ asserts stdout_valid_o with stdout_data_o = store data and waits for stdout_ready_i.
- When undefined, IO_ADDR is an ordinary memory address and the stdio ports do not exist.

Test Plan:
- Direct load: instr 16'h8A42, lsu_kind=1, ack after 3 cycles, rdata 16'h1234 -> mem_addr_o=8'h42, mem_we_o=0; RESP gives arf_wen_o=1, waddr=4'hA, wdata=16'h1234, done_o=1 for exactly one cycle.
- Indirect store: instr 16'hB305, rd_data 16'hBEEF, rt_data 16'h0177 -> mem_addr_o=8'h77, mem_we_o=1, mem_wdata_o=16'hBEEF; arf_wen_o stays 0, done_o pulses after ack.
- Zero-wait ack plus rd=0 load: instr 16'h8010, ack in first REQ cycle -> done_o at accept+2, arf_wen_o=0.
- Reset mid-REQ: assert rst_i during a 5-cycle ack wait -> mem_req_o=0 and busy_o=0 next cycle, no done_o; a fresh request afterwards completes normally.
- Back-to-back: lsu_en_i held high through RESP -> that second request is ignored and accepted only in the following IDLE cycle.
- TOY_LSU_STDIO_EN: load from 8'hFF with stdin_data 16'h0042 arriving after 2 cycles -> mem_req_o never rises, R[d]=16'h0042, done_o pulses; store to 8'hFF -> stdout_valid_o holds until stdout_ready_i.

Source files
------------

// File: rtl/core_lsu.sv
// core_lsu: single-outstanding load/store stage for the TOY core.
// Optional stdio port mapping at IO_ADDR is enabled by TOY_LSU_STDIO_EN.
module core_lsu #(
    parameter int              ADDR_W  = 8,
    parameter int              DATA_W  = 16,
    parameter logic [ADDR_W-1:0] IO_ADDR = 8'hFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_en_i,
    input  logic              lsu_wen_i,
    input  logic              lsu_kind_i,
    input  logic [15:0]       instr_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              arf_wen_o,
    output logic [3:0]        arf_waddr_o,
    output logic [DATA_W-1:0] arf_wdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
`ifdef TOY_LSU_STDIO_EN
    input  logic              stdin_valid_i,
    output logic              stdin_ready_o,
    input  logic [DATA_W-1:0] stdin_data_i,
    output logic              stdout_valid_o,
    input  logic              stdout_ready_i,
    output logic [DATA_W-1:0] stdout_data_o,
`endif
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic              wen_q, wen_d;
    logic [3:0]        rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              accept;
    logic              ack;
    logic [DATA_W-1:0] rdata_in;
    logic [ADDR_W-1:0] req_addr;
    logic              unused_ok;

    assign accept   = (state_q == S_IDLE) && lsu_en_i;
    assign req_addr = lsu_kind_i ? ADDR_W'(instr_i[7:0])
                                 : rt_data_i[ADDR_W-1:0];

`ifdef TOY_LSU_STDIO_EN
    logic io_q, io_d;

    // stdio handshakes stand in for the memory ack on IO_ADDR
    always_comb begin
        ack      = mem_ack_i;
        rdata_in = mem_rdata_i;
        if (io_q) begin
            ack      = wen_q ? stdout_ready_i : stdin_valid_i;
            rdata_in = stdin_data_i;
        end
    end

    always_comb begin
        io_d = io_q;
        if (accept) begin
            io_d = (req_addr == IO_ADDR);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            io_q <= 1'b0;
        end else begin
            io_q <= io_d;
        end
    end

    assign stdin_ready_o  = (state_q == S_REQ) && io_q && !wen_q;
    assign stdout_valid_o = (state_q == S_REQ) && io_q && wen_q;
    assign stdout_data_o  = wdata_q;
    assign unused_ok      = ^{instr_i[15:12], rt_data_i[DATA_W-1:ADDR_W]};
`else
    logic io_q;

    assign io_q      = 1'b0;
    assign ack       = mem_ack_i;
    assign rdata_in  = mem_rdata_i;
    assign unused_ok = ^{instr_i[15:12], rt_data_i[DATA_W-1:ADDR_W], IO_ADDR};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wen_q   <= 1'b0;
            rd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (lsu_en_i) state_d = S_REQ;
            S_REQ:   if (ack) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wen_d   = wen_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (accept) begin
            wen_d   = lsu_wen_i;
            rd_d    = instr_i[11:8];
            addr_d  = req_addr;
            wdata_d = rd_data_i;
        end
        if ((state_q == S_REQ) && ack) begin
            rdata_d = rdata_in;
        end
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_RESP);
        mem_req_o   = (state_q == S_REQ) && !io_q;
        mem_we_o    = mem_req_o && wen_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        // R0 is hard-wired zero, so loads into it only retire
        arf_wen_o   = (state_q == S_RESP) && !wen_q && (rd_q != 4'd0);
        arf_waddr_o = rd_q;
        arf_wdata_o = rdata_q;
    end

endmodule
